// File: rtl/restoring_divider_32b.sv
// Multi-cycle restoring divider: one shift / trial-subtract per clock with a start/busy/done handshake.
// Define DIVIDER_SIGNED_EN to add the signed_op port for two's-complement truncating division.
module restoring_divider_32b #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIVIDER_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    // DZERO is a one-cycle hop so a zero divisor reports done one edge after acceptance.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DZERO = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] dvsr_reg;
    logic [WIDTH-1:0] dvnd_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             dz_reg;
    logic [WIDTH-1:0] quot_reg;
    logic [WIDTH-1:0] rem_reg;

    logic [WIDTH-1:0] dvnd_mag;
    logic [WIDTH-1:0] dvsr_mag;
    logic             neg_q_in;
    logic             neg_r_in;
    logic             neg_q_reg;
    logic             neg_r_reg;

`ifdef DIVIDER_SIGNED_EN
    logic sgn_a;
    logic sgn_b;

    assign sgn_a    = signed_op & dividend[WIDTH-1];
    assign sgn_b    = signed_op & divisor[WIDTH-1];
    assign dvnd_mag = sgn_a ? (~dividend + WIDTH'(1)) : dividend;
    assign dvsr_mag = sgn_b ? (~divisor + WIDTH'(1)) : divisor;
    assign neg_q_in = sgn_a ^ sgn_b;
    assign neg_r_in = sgn_a;
`else
    assign dvnd_mag = dividend;
    assign dvsr_mag = divisor;
    assign neg_q_in = 1'b0;
    assign neg_r_in = 1'b0;
`endif

    // Trial subtract over WIDTH+1 bits so the bit shifted out of A is never lost.
    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_b_n;
    logic [WIDTH-1:0] trial_sum;
    logic [WIDTH+1:0] carry;
    logic             no_borrow;

    assign trial_a   = {a_reg, q_reg[WIDTH-1]};
    assign trial_b_n = ~{1'b0, dvsr_reg};
    assign carry[0]  = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi <= WIDTH; gi++) begin : g_sub
            if (gi < WIDTH) begin : g_sum
                assign trial_sum[gi] = trial_a[gi] ^ trial_b_n[gi] ^ carry[gi];
            end
            assign carry[gi+1] = (trial_a[gi] & trial_b_n[gi]) |
                                 (carry[gi] & (trial_a[gi] ^ trial_b_n[gi]));
        end
    endgenerate

    assign no_borrow = carry[WIDTH+1];

    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    always_comb begin
        a_next = no_borrow ? trial_sum : trial_a[WIDTH-1:0];
        q_next = {q_reg[WIDTH-2:0], no_borrow};
        q_fin  = neg_q_reg ? (~q_next + WIDTH'(1)) : q_next;
        r_fin  = neg_r_reg ? (~a_next + WIDTH'(1)) : a_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            q_reg     <= '0;
            dvsr_reg  <= '0;
            dvnd_reg  <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            dz_reg    <= 1'b0;
            quot_reg  <= '0;
            rem_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        dvsr_reg  <= dvsr_mag;
                        dvnd_reg  <= dividend;
                        a_reg     <= '0;
                        q_reg     <= dvnd_mag;
                        neg_q_reg <= neg_q_in;
                        neg_r_reg <= neg_r_in;
                        dz_reg    <= 1'b0;
                        if (divisor != '0) begin
                            cnt_reg   <= CW'(WIDTH);
                            busy_reg  <= 1'b1;
                            state_reg <= RUN;
                        end else begin
                            state_reg <= DZERO;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    a_reg   <= a_next;
                    q_reg   <= q_next;
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        quot_reg  <= q_fin;
                        rem_reg   <= r_fin;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DZERO: begin
                    quot_reg  <= '1;
                    rem_reg   <= dvnd_reg;
                    dz_reg    <= 1'b1;
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign quotient    = quot_reg;
    assign remainder   = rem_reg;
    assign div_by_zero = dz_reg;

endmodule

// File: tb/tb_restoring_divider_32b.sv
// Bench for restoring_divider_32b: directed operations, a cycle-level scoreboard model
// built from the accept/latency rules, and literal expectations for each operation.
module tb_restoring_divider_32b;

    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    wire         busy;
    wire         done;
    wire  [31:0] quotient;
    wire  [31:0] remainder;
    wire         div_by_zero;
    wire         sgn_in;

`ifdef DIVIDER_SIGNED_EN
    logic signed_op = 1'b0;
    assign sgn_in = signed_op;
`else
    assign sgn_in = 1'b0;
`endif

    restoring_divider_32b #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
`ifdef DIVIDER_SIGNED_EN
        .signed_op  (signed_op),
`endif
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain / and %, signed via 64-bit truncating division.
    function automatic logic [31:0] model_q(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 32'(sa / sb);
        end
        return a / b;
    endfunction

    function automatic logic [31:0] model_r(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        if (b == 32'd0) return a;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 32'(sa % sb);
        end
        return a % b;
    endfunction

    // Scoreboard: an operation accepted at edge e completes at edge e+WIDTH (e+1 for a zero divisor).
    int          edge_cnt = 0;
    int          ends_at = -1;
    logic        armed = 1'b0;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic        exp_dz = 1'b0;
    logic        exp_qr_known = 1'b0;
    logic        pend_dz = 1'b0;
    logic [31:0] exp_q = '0;
    logic [31:0] exp_r = '0;
    logic [31:0] pend_q = '0;
    logic [31:0] pend_r = '0;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (!rst_n) begin
            armed        <= 1'b1;
            ends_at      <= -1;
            exp_busy     <= 1'b0;
            exp_done     <= 1'b0;
            exp_dz       <= 1'b0;
            exp_q        <= '0;
            exp_r        <= '0;
            exp_qr_known <= 1'b1;
        end else if (start && edge_cnt > ends_at) begin
            ends_at      <= edge_cnt + ((divisor == 32'd0) ? 1 : WIDTH);
            pend_q       <= model_q(dividend, divisor, sgn_in);
            pend_r       <= model_r(dividend, divisor, sgn_in);
            pend_dz      <= (divisor == 32'd0);
            exp_busy     <= (divisor != 32'd0);
            exp_done     <= 1'b0;
            exp_dz       <= 1'b0;
            exp_qr_known <= 1'b0;
        end else if (edge_cnt == ends_at) begin
            exp_busy     <= 1'b0;
            exp_done     <= 1'b1;
            exp_q        <= pend_q;
            exp_r        <= pend_r;
            exp_dz       <= pend_dz;
            exp_qr_known <= 1'b1;
        end else begin
            exp_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            check("div_by_zero", 32'(div_by_zero), 32'(exp_dz));
            if (exp_qr_known) begin
                check("quotient", quotient, exp_q);
                check("remainder", remainder, exp_r);
            end
        end
    end

    // Call on a falling edge; returns on the falling edge after the accepting edge E0.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, output int e0);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e0       = edge_cnt;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_done(input int e0, input int lat, input int exp_busy_cnt, input string tag);
        int n = 0;
        int bcnt = 0;
        while (done !== 1'b1 && n < 60) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done not seen within 60 cycles", tag);
        end else begin
            check({tag, "_latency"}, 32'(edge_cnt), 32'(e0 + 1 + lat));
            check({tag, "_busy_cycles"}, 32'(bcnt), 32'(exp_busy_cnt));
        end
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[4] = '{
        '{32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 32'h7FFF_FFFE},
        '{32'hDEAD_BEEF, 32'h0000_0010, 32'h0DEA_DBEE, 32'h0000_000F},
        '{32'h1234_5678, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000},
        '{32'h0000_0005, 32'h0000_0009, 32'h0000_0000, 32'h0000_0005}
    };

    initial begin
        int e0;
        int cnt;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic divide.
        start_op(32'd100, 32'd7, e0);
        wait_done(e0, WIDTH, WIDTH, "t1");
        check("t1_q", quotient, 32'd14);
        check("t1_r", remainder, 32'd2);
        check("t1_dz", 32'(div_by_zero), 32'd0);
        @(negedge clk);

        // Extremes, second start issued in the done cycle.
        start_op(32'hFFFF_FFFF, 32'd1, e0);
        wait_done(e0, WIDTH, WIDTH, "t2a");
        check("t2a_q", quotient, 32'hFFFF_FFFF);
        check("t2a_r", remainder, 32'd0);
        start_op(32'd3, 32'hFFFF_FFFF, e0);
        wait_done(e0, WIDTH, WIDTH, "t2b");
        check("t2b_q", quotient, 32'd0);
        check("t2b_r", remainder, 32'd3);

        // More back-to-back directed vectors.
        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, e0);
            wait_done(e0, WIDTH, WIDTH, "vec");
            $display("vec %0d: %h / %h -> q=%h r=%h", i, vecs[i].a, vecs[i].b, quotient, remainder);
            check("vec_q", quotient, vecs[i].q);
            check("vec_r", remainder, vecs[i].r);
        end
        @(negedge clk);

        // Divide by zero.
        start_op(32'd5, 32'd0, e0);
        wait_done(e0, 1, 0, "t3");
        check("t3_q", quotient, 32'hFFFF_FFFF);
        check("t3_r", remainder, 32'd5);
        check("t3_dz", 32'(div_by_zero), 32'd1);
        @(negedge clk);
        check("t3_dz_held", 32'(div_by_zero), 32'd1);
        check("t3_done_drop", 32'(done), 32'd0);

        // Start while busy is ignored.
        start_op(32'd1000, 32'd10, e0);
        repeat (4) @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(e0, WIDTH, WIDTH - 5, "t4");
        check("t4_q", quotient, 32'd100);
        check("t4_r", remainder, 32'd0);
        check("t4_dz", 32'(div_by_zero), 32'd0);
        count_done(5, cnt);
        check("t4_extra_done", 32'(cnt), 32'd0);

        // Reset mid-operation.
        start_op(32'd50, 32'd5, e0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_q", quotient, 32'd0);
        check("t5_r", remainder, 32'd0);
        rst_n = 1'b1;
        count_done(40, cnt);
        check("t5_no_done", 32'(cnt), 32'd0);
        start_op(32'd7, 32'd2, e0);
        wait_done(e0, WIDTH, WIDTH, "t5b");
        check("t5b_q", quotient, 32'd3);
        check("t5b_r", remainder, 32'd1);
        @(negedge clk);

`ifdef DIVIDER_SIGNED_EN
        signed_op = 1'b1;
        start_op(32'hFFFF_FFF9, 32'd2, e0);
        wait_done(e0, WIDTH, WIDTH, "t6a");
        check("t6a_q", quotient, 32'hFFFF_FFFD);
        check("t6a_r", remainder, 32'hFFFF_FFFF);
        start_op(32'd7, 32'hFFFF_FFFE, e0);
        wait_done(e0, WIDTH, WIDTH, "t6b");
        check("t6b_q", quotient, 32'hFFFF_FFFD);
        check("t6b_r", remainder, 32'd1);
        start_op(32'h8000_0000, 32'hFFFF_FFFF, e0);
        wait_done(e0, WIDTH, WIDTH, "t6c");
        check("t6c_q", quotient, 32'h8000_0000);
        check("t6c_r", remainder, 32'd0);
        start_op(32'hFFFF_FFFB, 32'd0, e0);
        wait_done(e0, 1, 0, "t6d");
        check("t6d_q", quotient, 32'hFFFF_FFFF);
        check("t6d_r", remainder, 32'hFFFF_FFFB);
        check("t6d_dz", 32'(div_by_zero), 32'd1);
        signed_op = 1'b0;
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
